// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard/stall scheduler: Tuse/Tnew register hazards plus a mult/div busy counter,
// driving F/D write enables, the D/E bubble clear and a saturating stall-cycle counter.
module pipe_stall_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned PERF_W   = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [4:0]        d_rs_i,
    input  logic [4:0]        d_rt_i,
    input  logic [1:0]        d_tuse_rs_i,
    input  logic [1:0]        d_tuse_rt_i,
    input  logic              d_is_md_i,
    input  logic [4:0]        e_wa_i,
    input  logic [1:0]        e_tnew_i,
    input  logic [4:0]        m_wa_i,
    input  logic [1:0]        m_tnew_i,
    input  logic              e_md_start_i,
    input  logic              e_md_div_i,
    output logic              stall_o,
    output logic              f_we_o,
    output logic              d_we_o,
    output logic              e_clr_o,
    output logic              md_busy_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              rs_e, rs_m, rt_e, rt_m, md_h, stall;

    assign md_busy_o = (md_cnt_q != '0);

    // A hazard exists only when the producer's result arrives later than the consumer needs it.
    always_comb begin
        rs_e  = (e_wa_i != 5'd0) && (e_wa_i == d_rs_i) && (d_tuse_rs_i < e_tnew_i);
        rs_m  = (m_wa_i != 5'd0) && (m_wa_i == d_rs_i) && (d_tuse_rs_i < m_tnew_i);
        rt_e  = (e_wa_i != 5'd0) && (e_wa_i == d_rt_i) && (d_tuse_rt_i < e_tnew_i);
        rt_m  = (m_wa_i != 5'd0) && (m_wa_i == d_rt_i) && (d_tuse_rt_i < m_tnew_i);
        md_h  = d_is_md_i && (md_busy_o || e_md_start_i);
        stall = !reset_i && (rs_e || rs_m || rt_e || rt_m || md_h);
    end

    assign stall_o     = stall;
    assign f_we_o      = !stall;
    assign d_we_o      = !stall;
    assign e_clr_o     = stall;
    assign stall_cnt_o = stall_cnt_q;

    // A new start always reloads, so the newest mult/div op wins.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (e_md_start_i) begin
            md_cnt_d = e_md_div_i ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized and directed checks of pipe_stall_ctrl against a behavioural model;
// a second instance with a 4-bit perf counter exercises saturation.
module tb_pipe_stall_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [4:0]  d_rs_i, d_rt_i, e_wa_i, m_wa_i;
    logic [1:0]  d_tuse_rs_i, d_tuse_rt_i, e_tnew_i, m_tnew_i;
    logic        d_is_md_i, e_md_start_i, e_md_div_i;
    logic        stall_o, f_we_o, d_we_o, e_clr_o, md_busy_o;
    logic [15:0] stall_cnt_o;
    logic        stall4_o, f_we4_o, d_we4_o, e_clr4_o, md_busy4_o;
    logic [3:0]  stall_cnt4_o;

    int vectors = 0;
    int miscompares = 0;

    // Model state: remaining busy cycles and the two perf counts.
    int md_rem = 0;
    int perf16 = 0;
    int perf4  = 0;
    bit regs_known = 0;

    always #5 clk_i = ~clk_i;

    pipe_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4), .PERF_W(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .d_rs_i(d_rs_i), .d_rt_i(d_rt_i),
        .d_tuse_rs_i(d_tuse_rs_i), .d_tuse_rt_i(d_tuse_rt_i), .d_is_md_i(d_is_md_i),
        .e_wa_i(e_wa_i), .e_tnew_i(e_tnew_i), .m_wa_i(m_wa_i), .m_tnew_i(m_tnew_i),
        .e_md_start_i(e_md_start_i), .e_md_div_i(e_md_div_i), .stall_o(stall_o),
        .f_we_o(f_we_o), .d_we_o(d_we_o), .e_clr_o(e_clr_o), .md_busy_o(md_busy_o),
        .stall_cnt_o(stall_cnt_o)
    );

    pipe_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4), .PERF_W(4)) dut4 (
        .clk_i(clk_i), .reset_i(reset_i), .d_rs_i(d_rs_i), .d_rt_i(d_rt_i),
        .d_tuse_rs_i(d_tuse_rs_i), .d_tuse_rt_i(d_tuse_rt_i), .d_is_md_i(d_is_md_i),
        .e_wa_i(e_wa_i), .e_tnew_i(e_tnew_i), .m_wa_i(m_wa_i), .m_tnew_i(m_tnew_i),
        .e_md_start_i(e_md_start_i), .e_md_div_i(e_md_div_i), .stall_o(stall4_o),
        .f_we_o(f_we4_o), .d_we_o(d_we4_o), .e_clr_o(e_clr4_o), .md_busy_o(md_busy4_o),
        .stall_cnt_o(stall_cnt4_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit reg_hazard(input logic [4:0] wa, input logic [4:0] r,
                                      input int tuse, input int tnew);
        return (wa != 0) && (wa == r) && (tuse < tnew);
    endfunction

    function automatic bit model_stall();
        if (reset_i) return 1'b0;
        return reg_hazard(e_wa_i, d_rs_i, d_tuse_rs_i, e_tnew_i)
            || reg_hazard(m_wa_i, d_rs_i, d_tuse_rs_i, m_tnew_i)
            || reg_hazard(e_wa_i, d_rt_i, d_tuse_rt_i, e_tnew_i)
            || reg_hazard(m_wa_i, d_rt_i, d_tuse_rt_i, m_tnew_i)
            || (d_is_md_i && (md_rem > 0 || e_md_start_i));
    endfunction

    task automatic idle_inputs();
        reset_i = 0; d_rs_i = 0; d_rt_i = 0; d_tuse_rs_i = 3; d_tuse_rt_i = 3;
        d_is_md_i = 0; e_wa_i = 0; e_tnew_i = 0; m_wa_i = 0; m_tnew_i = 0;
        e_md_start_i = 0; e_md_div_i = 0;
    endtask

    // Let combinational outputs settle, then compare everything against the model.
    task automatic settle_check();
        bit s;
        #1;
        s = model_stall();
        check_val("stall", stall_o, s);
        check_val("f_we", f_we_o, !s);
        check_val("d_we", d_we_o, !s);
        check_val("e_clr", e_clr_o, s);
        check_val("stall4", stall4_o, s);
        if (regs_known) begin
            check_val("md_busy", md_busy_o, md_rem > 0);
            check_val("stall_cnt", stall_cnt_o, perf16);
            check_val("stall_cnt4", stall_cnt4_o, perf4);
        end
    endtask

    task automatic tick();
        bit s;
        s = model_stall();
        @(posedge clk_i);
        if (reset_i) begin
            md_rem = 0; perf16 = 0; perf4 = 0; regs_known = 1;
        end else begin
            if (e_md_start_i) md_rem = e_md_div_i ? 10 : 5;
            else if (md_rem > 0) md_rem--;
            if (s && perf16 < 65535) perf16++;
            if (s && perf4 < 15) perf4++;
        end
        @(negedge clk_i);
    endtask

    task automatic md_run(input bit is_div, input bit is_md, input int exp_stall,
                          input int exp_busy, input string tag);
        int ns = 0;
        int nb = 0;
        idle_inputs();
        d_is_md_i = is_md; e_md_start_i = 1; e_md_div_i = is_div;
        for (int i = 0; i < 14; i++) begin
            settle_check();
            ns += int'(stall_o);
            nb += int'(md_busy_o);
            tick();
            e_md_start_i = 0;
        end
        check_val({tag, "_stall_cycles"}, ns, exp_stall);
        check_val({tag, "_busy_cycles"}, nb, exp_busy);
    endtask

    initial begin
        @(negedge clk_i);
        idle_inputs();
        // Reset with a hazard present: stall must stay low.
        reset_i = 1; e_wa_i = 8; e_tnew_i = 2; d_rs_i = 8; d_tuse_rs_i = 0;
        settle_check();
        check_val("reset_stall", stall_o, 0);
        check_val("reset_f_we", f_we_o, 1);
        tick();
        reset_i = 0;
        idle_inputs();
        settle_check();
        check_val("reset_busy", md_busy_o, 0);
        check_val("reset_cnt", stall_cnt_o, 0);
        tick();

        // Load-use then draining through M.
        e_wa_i = 8; e_tnew_i = 2; d_rs_i = 8; d_tuse_rs_i = 0;
        settle_check();
        check_val("lu_stall", stall_o, 1);
        check_val("lu_e_clr", e_clr_o, 1);
        check_val("lu_d_we", d_we_o, 0);
        tick();
        e_wa_i = 0; m_wa_i = 8; m_tnew_i = 1;
        settle_check();
        check_val("lu_m_stall", stall_o, 1);
        tick();
        m_tnew_i = 0;
        settle_check();
        check_val("lu_m_ready", stall_o, 0);
        tick();

        // Register 0 and no-use cases.
        idle_inputs(); e_wa_i = 0; d_rs_i = 0; e_tnew_i = 2; d_tuse_rs_i = 0;
        settle_check(); check_val("r0_nostall", stall_o, 0); tick();
        idle_inputs(); e_wa_i = 9; d_rt_i = 9; e_tnew_i = 2; d_tuse_rt_i = 3;
        settle_check(); check_val("nouse_nostall", stall_o, 0); tick();
        idle_inputs(); e_wa_i = 9; d_rt_i = 9; e_tnew_i = 1; d_tuse_rt_i = 1;
        settle_check(); check_val("inTime_nostall", stall_o, 0); tick();

        md_run(0, 1, 6, 5, "mult");
        md_run(1, 1, 11, 10, "div");
        md_run(1, 0, 0, 10, "div_nomd");

        // Reset mid-divide at md_cnt = 7.
        idle_inputs(); d_is_md_i = 1; e_md_start_i = 1; e_md_div_i = 1;
        settle_check(); tick();
        e_md_start_i = 0;
        for (int i = 0; i < 3; i++) begin settle_check(); tick(); end
        reset_i = 1;
        settle_check(); check_val("rst_mid_stall", stall_o, 0); tick();
        reset_i = 0;
        settle_check();
        check_val("rst_mid_busy", md_busy_o, 0);
        check_val("rst_mid_cnt", stall_cnt_o, 0);
        check_val("rst_mid_stall2", stall_o, 0);
        tick();

        // Saturation of the 4-bit perf counter.
        idle_inputs(); reset_i = 1; settle_check(); tick();
        idle_inputs(); e_wa_i = 8; e_tnew_i = 2; d_rs_i = 8; d_tuse_rs_i = 0;
        for (int i = 0; i < 20; i++) begin settle_check(); tick(); end
        settle_check();
        check_val("sat_cnt4", stall_cnt4_o, 15);
        check_val("sat_cnt16", stall_cnt_o, 20);
        tick();

        // Randomized traffic, biased to small register indices so hazards actually occur.
        for (int i = 0; i < 400; i++) begin
            reset_i      = ($urandom_range(0, 49) == 0);
            d_rs_i       = 5'($urandom_range(0, 3));
            d_rt_i       = 5'($urandom_range(0, 3));
            e_wa_i       = 5'($urandom_range(0, 3));
            m_wa_i       = 5'($urandom_range(0, 3));
            d_tuse_rs_i  = 2'($urandom);
            d_tuse_rt_i  = 2'($urandom);
            e_tnew_i     = 2'($urandom);
            m_tnew_i     = 2'($urandom);
            d_is_md_i    = ($urandom_range(0, 3) == 0);
            e_md_start_i = ($urandom_range(0, 9) == 0);
            e_md_div_i   = 1'($urandom);
            settle_check();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
